rob_scheduler: RTL and testbench

// Sequences all traffic into the 32-entry reorder buffer. Each cycle it grants at most one of

---
 rtl/rob_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_rob_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_scheduler.sv
// rob_scheduler: single-grant arbiter in front of a reorder buffer. Mirrors head/tail/count
// and per-slot valid/done bitmaps, and issues at most one registered ROB op per cycle.
module rob_scheduler #(
    parameter int DEPTH        = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alloc_req,
    input  logic [4:0]    alloc_reg,
    output logic          alloc_ack,
    output logic [AW-1:0] alloc_tag,
    input  logic          wb_req,
    input  logic [AW-1:0] wb_tag,
    input  logic [31:0]   wb_data,
    output logic          wb_ack,
    input  logic          commit_en,
    input  logic          drain_req,
    input  logic          flush,
    output logic [2:0]    rob_code,
    output logic [AW-1:0] rob_pc,
    output logic [4:0]    rob_reg,
    output logic [31:0]   rob_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          drained,
    output logic          wb_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO   = {(AW + 1){1'b0}};
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             wb_err_q, wb_err_d;
    logic [2:0]       code_q, code_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [4:0]       reg_q, reg_d;
    logic [31:0]      data_q, data_d;

    logic full_s, empty_s, blocked_s, commit_elig_s, alloc_elig_s;
    logic grant_alloc_s, grant_wb_s, grant_commit_s;

    assign full_s        = (count_q == CNT_FULL);
    assign empty_s       = (count_q == CNT_ZERO);
    // A flush request and the FLUSH cycle itself both suppress every grant.
    assign blocked_s     = flush | (state_q == ST_FLUSH);
    assign commit_elig_s = commit_en & ~empty_s & done_q[head_q];
    assign alloc_elig_s  = alloc_req & ~full_s & (state_q == ST_RUN);

    // Grant selection: commit > wb > alloc, unless alloc has been starved long enough.
    always_comb begin
        grant_alloc_s  = 1'b0;
        grant_wb_s     = 1'b0;
        grant_commit_s = 1'b0;
        if (blocked_s) begin
            grant_alloc_s = 1'b0;
        end else if (alloc_elig_s && (starve_q >= STARVE_MAX)) begin
            grant_alloc_s = 1'b1;
        end else if (commit_elig_s) begin
            grant_commit_s = 1'b1;
        end else if (wb_req) begin
            grant_wb_s = 1'b1;
        end else if (alloc_elig_s) begin
            grant_alloc_s = 1'b1;
        end else begin
            grant_alloc_s = 1'b0;
        end
    end

    // Next-state for pointers, bitmaps, starvation counter, FSM and the ROB op register.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid_d  = valid_q;
        done_d   = done_q;
        starve_d = starve_q;
        wb_err_d = wb_err_q;
        code_d   = 3'b000;
        pc_d     = {AW{1'b0}};
        reg_d    = 5'd0;
        data_d   = 32'd0;

        if (blocked_s) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = CNT_ZERO;
            valid_d = {DEPTH{1'b0}};
            done_d  = {DEPTH{1'b0}};
        end else if (grant_alloc_s) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + 1'b1;
            count_d         = count_q + 1'b1;
            code_d          = 3'b100;
            pc_d            = tail_q;
            reg_d           = alloc_reg;
        end else if (grant_commit_s) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + 1'b1;
            count_d         = count_q - 1'b1;
            code_d          = 3'b001;
            pc_d            = head_q;
        end else if (grant_wb_s) begin
            if (valid_q[wb_tag]) begin
                done_d[wb_tag] = 1'b1;
                code_d         = 3'b010;
                pc_d           = wb_tag;
                data_d         = wb_data;
            end else begin
                wb_err_d = 1'b1;
            end
        end else begin
            code_d = 3'b000;
        end

        if (blocked_s) begin
            starve_d = starve_q;
        end else if (grant_alloc_s) begin
            starve_d = {SW{1'b0}};
        end else if (alloc_elig_s && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end

        if (flush) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN:   state_d = drain_req ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_d = drain_req ? ST_DRAIN : ST_RUN;
                ST_FLUSH: state_d = drain_req ? ST_DRAIN : ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            head_q   <= {AW{1'b0}};
            tail_q   <= {AW{1'b0}};
            count_q  <= CNT_ZERO;
            valid_q  <= {DEPTH{1'b0}};
            done_q   <= {DEPTH{1'b0}};
            starve_q <= {SW{1'b0}};
            wb_err_q <= 1'b0;
            code_q   <= 3'b000;
            pc_q     <= {AW{1'b0}};
            reg_q    <= 5'd0;
            data_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            starve_q <= starve_d;
            wb_err_q <= wb_err_d;
            code_q   <= code_d;
            pc_q     <= pc_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
        end
    end

    assign alloc_ack = grant_alloc_s;
    assign alloc_tag = tail_q;
    assign wb_ack    = grant_wb_s;
    assign rob_code  = code_q;
    assign rob_pc    = pc_q;
    assign rob_reg   = reg_q;
    assign rob_data  = data_q;
    assign count     = count_q;
    assign full      = full_s;
    assign empty     = empty_s;
    assign drained   = (state_q == ST_DRAIN) && empty_s;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_rob_scheduler.sv
// tb_rob_scheduler: directed scenarios plus randomized traffic, checked every cycle against
// a queue-based model of the reorder buffer's occupancy, completion and retirement.
module tb_rob_scheduler;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_req;
    logic [4:0]  alloc_reg;
    logic        alloc_ack;
    logic [4:0]  alloc_tag;
    logic        wb_req;
    logic [4:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_ack;
    logic        commit_en;
    logic        drain_req;
    logic        flush;
    logic [2:0]  rob_code;
    logic [4:0]  rob_pc;
    logic [4:0]  rob_reg;
    logic [31:0] rob_data;
    logic [5:0]  count;
    logic        full;
    logic        empty;
    logic        drained;
    logic        wb_err;

    always #5 clk = ~clk;

    rob_scheduler dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_reg(alloc_reg), .alloc_ack(alloc_ack), .alloc_tag(alloc_tag),
        .wb_req(wb_req), .wb_tag(wb_tag), .wb_data(wb_data), .wb_ack(wb_ack),
        .commit_en(commit_en), .drain_req(drain_req), .flush(flush),
        .rob_code(rob_code), .rob_pc(rob_pc), .rob_reg(rob_reg), .rob_data(rob_data),
        .count(count), .full(full), .empty(empty), .drained(drained), .wb_err(wb_err)
    );

    int errors = 0;
    int checks = 0;

    // Model: live entries in program order, completion flags, next tag, mode 0 run/1 drain/2 flush.
    int          q[$];
    bit          mdone[32];
    int          mtail;
    int          mstarve;
    int          mmode;
    bit          merr;
    logic [2:0]  e_code;
    int          e_pc;
    int          e_reg;
    logic [31:0] e_data;
    bit          last_alloc_ack;
    bit          last_wb_ack;
    int          last_alloc_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) mdone[i] = 1'b0;
        mtail = 0; mstarve = 0; mmode = 0; merr = 1'b0;
        e_code = 3'b000; e_pc = 0; e_reg = 0; e_data = 32'd0;
        last_alloc_ack = 1'b0; last_wb_ack = 1'b0; last_alloc_tag = 0;
    endtask

    function automatic bit is_live(input int tag);
        foreach (q[i]) if (q[i] == tag) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: settle, compare everything against the model, advance the model, next negedge.
    task automatic step();
        int g;
        bit full_m, empty_m, blocked, c_el, a_el;
        #1;
        if (reset) begin
            model_reset();
        end else begin
            full_m  = (q.size() == 32);
            empty_m = (q.size() == 0);
            blocked = flush || (mmode == 2);
            c_el    = 1'b0;
            if (!empty_m) c_el = commit_en && mdone[q[0]];
            a_el    = alloc_req && !full_m && (mmode == 0);
            g = 0;
            if (!blocked) begin
                if (a_el && mstarve >= LIMIT) g = 1;
                else if (c_el)                g = 3;
                else if (wb_req)              g = 2;
                else if (a_el)                g = 1;
            end
            check("alloc_ack", alloc_ack, g == 1);
            if (g == 1) check("alloc_tag", alloc_tag, mtail);
            check("wb_ack", wb_ack, g == 2);
            check("count", count, q.size());
            check("full", full, full_m);
            check("empty", empty, empty_m);
            check("drained", drained, (mmode == 1) && empty_m);
            check("wb_err", wb_err, merr);
            check("rob_code", rob_code, e_code);
            check("rob_pc", rob_pc, e_pc);
            check("rob_reg", rob_reg, e_reg);
            check("rob_data", rob_data, e_data);
            last_alloc_ack = alloc_ack;
            last_wb_ack    = wb_ack;
            last_alloc_tag = alloc_tag;

            e_code = 3'b000; e_pc = 0; e_reg = 0; e_data = 32'd0;
            if (blocked) begin
                q.delete();
                for (int i = 0; i < 32; i++) mdone[i] = 1'b0;
                mtail = 0;
            end else begin
                case (g)
                    1: begin
                        q.push_back(mtail);
                        mdone[mtail] = 1'b0;
                        e_code = 3'b100; e_pc = mtail; e_reg = alloc_reg;
                        mtail = (mtail + 1) % 32;
                    end
                    2: begin
                        if (is_live(wb_tag)) begin
                            mdone[wb_tag] = 1'b1;
                            e_code = 3'b010; e_pc = wb_tag; e_data = wb_data;
                        end else begin
                            merr = 1'b1;
                        end
                    end
                    3: begin
                        e_code = 3'b001; e_pc = q[0];
                        mdone[q[0]] = 1'b0;
                        void'(q.pop_front());
                    end
                    default: ;
                endcase
                if (g == 1)    mstarve = 0;
                else if (a_el) mstarve = (mstarve < LIMIT) ? mstarve + 1 : LIMIT;
            end
            mmode = flush ? 2 : (drain_req ? 1 : 0);
        end
        @(negedge clk);
    endtask

    initial begin
        int got_cycle;
        reset = 1'b1; alloc_req = 1'b0; alloc_reg = 5'd0; wb_req = 1'b0; wb_tag = 5'd0;
        wb_data = 32'd0; commit_en = 1'b0; drain_req = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_code", rob_code, 3'b000);
        check("rst_wb_err", wb_err, 0);
        step();

        // Three allocations get tags 0,1,2 and show up one cycle later.
        for (int i = 0; i < 3; i++) begin
            alloc_req = 1'b1; alloc_reg = 5'(5 + i);
            step();
            check("t1_ack", last_alloc_ack, 1);
            check("t1_tag", last_alloc_tag, i);
            check("t1_code", rob_code, 3'b100);
            check("t1_pc", rob_pc, i);
            check("t1_reg", rob_reg, 5 + i);
        end
        alloc_req = 1'b0;
        check("t1_count", count, 3);

        // Complete slot 0, then commit, wb and alloc contend in the same cycle.
        wb_req = 1'b1; wb_tag = 5'd0; wb_data = 32'h1111;
        step();
        wb_req = 1'b1; wb_tag = 5'd1; wb_data = 32'hABCD;
        alloc_req = 1'b1; alloc_reg = 5'd8; commit_en = 1'b1;
        step();
        check("t2_commit_code", rob_code, 3'b001);
        check("t2_commit_pc", rob_pc, 0);
        check("t2_no_wb_ack", last_wb_ack, 0);
        commit_en = 1'b0;
        step();
        check("t2_wb_code", rob_code, 3'b010);
        check("t2_wb_data", rob_data, 32'hABCD);
        wb_req = 1'b0;
        step();
        check("t2_alloc_ack", last_alloc_ack, 1);
        check("t2_alloc_tag", last_alloc_tag, 3);
        alloc_req = 1'b0;
        check("t2_count", count, 3);

        // Fill after a flush, confirm full blocks alloc, then wrap the tail.
        flush = 1'b1; step(); flush = 1'b0; step();
        check("t3_flushed", count, 0);
        alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) begin alloc_reg = 5'(i); step(); end
        check("t3_full", full, 1);
        check("t3_count32", count, 32);
        step();
        check("t3_full_noack", last_alloc_ack, 0);
        alloc_req = 1'b0;
        wb_req = 1'b1; wb_tag = 5'd0; step(); wb_req = 1'b0;
        commit_en = 1'b1; step(); commit_en = 1'b0;
        check("t3_count31", count, 31);
        alloc_req = 1'b1; step(); alloc_req = 1'b0;
        check("t3_wrap_tag", last_alloc_tag, 0);

        // Writeback to an unallocated slot.
        flush = 1'b1; step(); flush = 1'b0; step();
        wb_req = 1'b1; wb_tag = 5'd9; wb_data = 32'h5A5A;
        step();
        wb_req = 1'b0;
        check("t4_wb_ack", last_wb_ack, 1);
        check("t4_code", rob_code, 3'b000);
        check("t4_err", wb_err, 1);
        step(); step();
        check("t4_err_sticky", wb_err, 1);

        // Starvation: continuous wb traffic must not hold off alloc past the 5th cycle.
        got_cycle = 0;
        wb_req = 1'b1; alloc_req = 1'b1; alloc_reg = 5'd3;
        for (int i = 0; i < 8 && got_cycle == 0; i++) begin
            wb_tag = 5'($urandom); wb_data = $urandom;
            step();
            if (last_alloc_ack) got_cycle = i + 1;
        end
        wb_req = 1'b0; alloc_req = 1'b0;
        check("t5_grant_cycle", got_cycle, 5);

        // Flush with 10 live entries, then drain two completed entries.
        alloc_req = 1'b1;
        for (int i = 0; i < 9; i++) step();
        alloc_req = 1'b0;
        check("t6_count10", count, 10);
        flush = 1'b1; wb_req = 1'b1; wb_tag = 5'd2;
        step();
        check("t6_flush_wb_ack", last_wb_ack, 0);
        flush = 1'b0; wb_req = 1'b0;
        check("t6_count0", count, 0);
        check("t6_empty", empty, 1);
        step();
        alloc_req = 1'b1; step(); step(); alloc_req = 1'b0;
        wb_req = 1'b1; wb_tag = 5'd0; step(); wb_tag = 5'd1; step(); wb_req = 1'b0;
        drain_req = 1'b1; commit_en = 1'b1;
        step(); step(); step();
        check("t6_drained", drained, 1);
        check("t6_drain_count", count, 0);
        drain_req = 1'b0; commit_en = 1'b0;
        step();

        // Randomized traffic; requesters hold until acked.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 599) == 0);
            if (!alloc_req || last_alloc_ack) begin
                alloc_req = 1'($urandom_range(0, 1)); alloc_reg = 5'($urandom);
            end
            if (!wb_req || last_wb_ack) begin
                wb_req = ($urandom_range(0, 2) != 0);
                if (q.size() > 0 && $urandom_range(0, 7) != 0)
                    wb_tag = 5'(q[$urandom_range(0, q.size() - 1)]);
                else
                    wb_tag = 5'($urandom);
                wb_data = $urandom;
            end
            commit_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) drain_req = ~drain_req;
            flush = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
